// File: rtl/writeback_if.sv
// WB-stage bundle: held MA/WB register contents, ID read ports, EX forwarding tap
// and retire bookkeeping. The master drives the pipeline side; the slave is writeback.
interface writeback_if #(
  parameter int INSTRET_W = 64
);
  logic                 stall;
  logic [63:0]          pc;
  logic [4:0]           rd;
  logic [63:0]          data;
  logic [4:0]           rs1;
  logic [4:0]           rs2;
  logic [63:0]          rs1_data;
  logic [63:0]          rs2_data;
  logic [4:0]           fwd_rd;
  logic [63:0]          fwd_data;
  logic                 retire;
  logic [63:0]          retire_pc;
  logic [INSTRET_W-1:0] instret;

  modport master (
    output stall, pc, rd, data, rs1, rs2,
    input  rs1_data, rs2_data, fwd_rd, fwd_data, retire, retire_pc, instret
  );

  modport slave (
    input  stall, pc, rd, data, rs1, rs2,
    output rs1_data, rs2_data, fwd_rd, fwd_data, retire, retire_pc, instret
  );
endinterface

// File: rtl/writeback.sv
// Final stage: commits each WB instruction once into the 32x64 regfile, reads with bypass.
// Reads/forwarding are combinational; retire/instret follow commit by 1 cycle; a held instruction commits once.
module writeback #(
  parameter int INSTRET_W = 64
) (
  input  logic       clk,
  input  logic       rst,
  writeback_if.slave wb
);

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [63:0]          regs [32];
  logic                 valid;
  logic                 committed;
  logic                 commit_en;
  logic                 wr_en;
  logic                 retire_q;
  logic [63:0]          retire_pc_q;
  logic [INSTRET_W-1:0] instret_q;

  assign valid     = (wb.pc != 64'd0);
  assign committed = (state_q == HELD);
  assign commit_en = valid & ~committed;
  assign wr_en     = commit_en & (wb.rd != 5'd0);

  // HELD marks "this stalled instruction already committed"; any unstalled edge clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (commit_en && wb.stall) begin
          state_d = HELD;
        end
      end
      HELD: begin
        if (wb.stall) begin
          state_d = HELD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 64'd0;
      end
    end else if (wr_en) begin
      regs[wb.rd] <= wb.data;
    end
  end

  // Bypass keys on valid/rd only, so stall never reaches the read outputs.
  function automatic logic [63:0] read_port(input logic [4:0] rs);
    logic [63:0] val;
    val = 64'd0;
    if (rs == 5'd0) begin
      val = 64'd0;
    end else if (valid && (wb.rd != 5'd0) && (rs == wb.rd)) begin
      val = wb.data;
    end else begin
      val = regs[rs];
    end
    return val;
  endfunction

  assign wb.rs1_data = read_port(wb.rs1);
  assign wb.rs2_data = read_port(wb.rs2);

  assign wb.fwd_rd   = (valid && (wb.rd != 5'd0)) ? wb.rd : 5'd0;
  assign wb.fwd_data = wb.data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_q    <= 1'b0;
      retire_pc_q <= 64'd0;
      instret_q   <= '0;
    end else begin
      retire_q  <= commit_en;
      instret_q <= instret_q + {{(INSTRET_W-1){1'b0}}, commit_en};
      if (commit_en) begin
        retire_pc_q <= wb.pc;
      end
    end
  end

  assign wb.retire    = retire_q;
  assign wb.retire_pc = retire_pc_q;
  assign wb.instret   = instret_q;

endmodule

// File: doc/writeback.md
Name: writeback

Overview:
- Final pipeline stage. It consumes the MA/WB pipeline register outputs: pc, rd and the loaded or computed data.
- Commits each instruction exactly once into the 32x64 integer register file.
- Serves the ID-stage register reads with same-cycle write bypass.
- Exports the forwarding tap used by EX, plus retire/instret bookkeeping.
- Honours the global stall, so a held WB instruction is never double-counted.

Parameters:
INSTRET_W, 64, width of retired-instruction counter (wraps modulo 2^INSTRET_W)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
stall  input  1  global pipeline stall (MA blocked); WB inputs held stable while high
pc  input  64  pc of instruction in WB; 0 = bubble
rd  input  5  destination register; 0 = no write
data  input  64  result to write
rs1  input  5  ID read address 1
rs2  input  5  ID read address 2
rs1_data  output  64  read data 1 (combinational)
rs2_data  output  64  read data 2 (combinational)
fwd_rd  output  5  forwarding tag for EX; 0 when nothing valid
fwd_data  output  64  forwarding value for EX
retire  output  1  registered one-cycle pulse per committed instruction
retire_pc  output  64  pc of last committed instruction (registered)
instret  output  INSTRET_W  count of committed instructions

Behaviour:
- Reset (async assert, sync release):
  - all 31 regs x1..x31 = 0
  - committed = 0, retire = 0, retire_pc = 0, instret = 0
- valid = (pc != 0).
- commit_en = valid & ~committed.
- committed flag (the only control state; two states, IDLE/HELD):
  - next = stall ? (committed | commit_en) : 0.
  - IDLE -> HELD when commit_en & stall.
  - HELD -> IDLE when ~stall.
  - In HELD, no further commit for the same held instruction.
- Register write: on posedge with commit_en & (rd != 0), reg[rd] <= data.
  - Write to x0 is silently dropped.
  - Bubble (pc = 0) never writes, even if rd != 0.
- Reads are combinational:
  - rsX == 0 -> 0.
  - else if valid & rd != 0 & rsX == rd -> data (bypass; applies in HELD too, value identical).
  - else reg[rsX].
  - rs1 == rs2 is legal; both outputs are identical.
- Forwarding:
  - fwd_rd = (valid & rd != 0) ? rd : 0; fwd_data = data.
  - Both remain asserted for the whole stall so EX forwarding stays consistent.
- Retire:
  - retire <= commit_en; retire_pc <= commit_en ? pc : retire_pc.
  - instret <= instret + commit_en, wrapping from all-ones to 0.
  - Latency from commit cycle to retire/instret visible: 1 cycle.
- Back-to-back commits with stall = 0 produce retire high in consecutive cycles.
- Same pc entering twice consecutively with stall = 0 is two distinct instructions; both commit.
- Reset mid-stall:
  - committed cleared; regs zeroed.
  - After release, an instruction still presented is committed once.
- No combinational path from stall to any read output.

Test Plan:
- Reset then read: rst pulse; rs1 = 5, rs2 = 0 -> rs1_data = 0, rs2_data = 0, instret = 0, retire = 0.
- Simple commit:
  - pc = 0x80000000, rd = 3, data = 0xDEAD, stall = 0 for 1 cycle, then bubble.
  - Next cycle: rs1 = 3 -> 0xDEAD; retire = 1, retire_pc = 0x80000000, instret = 1.
- Stall hold:
  - pc = 0x80000004, rd = 7, data = 0x55, stall = 1 for 4 cycles, then 0.
  - Exactly one retire pulse; instret increments by 1.
  - fwd_rd = 7, fwd_data = 0x55 throughout; reg x7 = 0x55.
- Bypass and x0:
  - pc = 0x80000008, rd = 9, data = 0x1234 with rs1 = 9, rs2 = 9 -> both 0x1234 same cycle.
  - rd = 0, data = 0xFF -> x0 reads 0, fwd_rd = 0, instret still increments.
- Bubble:
  - pc = 0, rd = 4, data = 0x77 -> no write (x4 stays 0), no retire, fwd_rd = 0.
- Wrap and reset mid-op:
  - Preload instret = all-ones via force, commit once -> instret = 0.
  - Assert rst while stall = 1 in HELD; release with same instruction held -> one retire after release.
